// File: rtl/vpp_track_mc.sv
`default_nettype none
// ============================================================================
// Module   : vpp_track_mc
// Brief    : Multi-channel peak-to-peak tracker. Each start measures one
//            window of 'times' strobed samples per channel and publishes
//            max, min and vpp (max - min) per channel.
// Options  : VPP_AVG_EN - when defined, 2**AVG_LOG2 consecutive windows are
//            measured per start and vpp is their truncated mean.
// Revision : 1.0 - initial release
// ============================================================================
module vpp_track_mc #(
  parameter int DW       = 12,
  parameter int CH       = 2,
  parameter int CNT_W    = 32,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [CH*DW-1:0]  din,
  input  logic [CNT_W-1:0]  times,
  input  logic              start,
  input  logic              clr,
  output logic              busy,
  output logic [CH*DW-1:0]  max,
  output logic [CH*DW-1:0]  min,
  output logic [CH*DW-1:0]  vpp,
  output logic              done,
  output logic              valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

`ifdef VPP_AVG_EN
  localparam int AW  = DW + AVG_LOG2;
  localparam int WCW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
`else
  // AVG_LOG2 has no effect without averaging: the published vpp is unshifted
  localparam int NO_SHIFT = 0 * AVG_LOG2;
`endif

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             rst_meta;
  logic             rst_sync_n;
  logic [CNT_W-1:0] times_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             last_win;
  logic             accept_start;
  logic             take;
  logic             win_close;
  logic             meas_close;
  logic             publish;

  // Reset asserts asynchronously but releases only after two clean clock edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= S_IDLE;
    else             state <= state_nxt;
  end

  // FSM next-state: clr aborts from anywhere, start is only seen in IDLE
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start)      state_nxt = S_ACC;
        S_ACC:   if (meas_close) state_nxt = S_FIN;
        S_FIN:                   state_nxt = S_IDLE;
        default:                 state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs and datapath qualifiers
  always_comb begin
    busy         = (state != S_IDLE);
    accept_start = (state == S_IDLE) && start && !clr;
    take         = (state == S_ACC) && sample_en && !clr;
    win_close    = take && cnt_last;
    meas_close   = win_close && last_win;
    publish      = (state == S_FIN) && !clr;
  end

  // Window length of zero behaves as one; times-1 is the closing count so the
  // counter never has to reach 2**CNT_W
  assign cnt_last = (cnt == (times_q - CNT_W'(1)));

  // Latched window length and per-window sample counter
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      times_q <= '0;
      cnt     <= '0;
    end else if (accept_start) begin
      times_q <= (times == '0) ? CNT_W'(1) : times;
      cnt     <= '0;
    end else if (take) begin
      cnt     <= win_close ? '0 : cnt + CNT_W'(1);
    end
  end

`ifdef VPP_AVG_EN
  logic [WCW-1:0] win_cnt;

  assign last_win = (win_cnt == WCW'((1 << AVG_LOG2) - 1));

  // Counts closed windows within one averaged measurement
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n)       win_cnt <= '0;
    else if (accept_start) win_cnt <= '0;
    else if (win_close)    win_cnt <= win_cnt + WCW'(1);
  end
`else
  assign last_win = 1'b1;
`endif

  // Publish strobe and sticky result-valid flag
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      done  <= 1'b0;
      valid <= 1'b0;
    end else begin
      done  <= publish;
      valid <= valid | publish;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [DW-1:0] s;
    logic [DW-1:0] run_max;
    logic [DW-1:0] run_min;
    logic [DW-1:0] nmax;
    logic [DW-1:0] nmin;
    logic [DW-1:0] wvpp;
    logic [DW-1:0] last_max;
    logic [DW-1:0] last_min;
    logic [DW-1:0] max_q;
    logic [DW-1:0] min_q;
    logic [DW-1:0] vpp_q;

    assign s    = din[k*DW +: DW];
    assign nmax = (s > run_max) ? s : run_max;
    assign nmin = (s < run_min) ? s : run_min;
    // A closing window always holds at least one sample, so nmax >= nmin
    assign wvpp = nmax - nmin;

    // Running extremes, re-seeded at every window close
    always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
        run_max <= '0;
        run_min <= '1;
      end else if (accept_start || win_close) begin
        run_max <= '0;
        run_min <= '1;
      end else if (take) begin
        run_max <= nmax;
        run_min <= nmin;
      end
    end

    // Snapshot of the extremes of the most recently closed window
    always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
        last_max <= '0;
        last_min <= '0;
      end else if (win_close) begin
        last_max <= nmax;
        last_min <= nmin;
      end
    end

`ifdef VPP_AVG_EN
    logic [AW-1:0] acc;

    // Sum of window vpp values across the averaged measurement
    always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n)       acc <= '0;
      else if (accept_start) acc <= '0;
      else if (win_close)    acc <= acc + AW'(wvpp);
    end

    // Result registers load once per measurement; mean is a truncating shift
    always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
        max_q <= '0;
        min_q <= '0;
        vpp_q <= '0;
      end else if (publish) begin
        max_q <= last_max;
        min_q <= last_min;
        vpp_q <= acc[AVG_LOG2 +: DW];
      end
    end
`else
    logic [DW-1:0] last_vpp;

    // Peak-to-peak of the closed window
    always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n)    last_vpp <= '0;
      else if (win_close) last_vpp <= wvpp;
    end

    // Result registers load once per measurement
    always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
        max_q <= '0;
        min_q <= '0;
        vpp_q <= '0;
      end else if (publish) begin
        max_q <= last_max;
        min_q <= last_min;
        vpp_q <= last_vpp >> NO_SHIFT;
      end
    end
`endif

    assign max[k*DW +: DW] = max_q;
    assign min[k*DW +: DW] = min_q;
    assign vpp[k*DW +: DW] = vpp_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_vpp_track_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_vpp_track_mc
// Brief    : Directed self-checking bench for vpp_track_mc (DW=12, CH=2).
//            With VPP_AVG_EN defined the averaging scenario replaces the
//            single-window scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vpp_track_mc;

  localparam int DW       = 12;
  localparam int CH       = 2;
  localparam int CNT_W    = 32;
  localparam int AVG_LOG2 = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sample_en;
  logic [CH*DW-1:0]  din;
  logic [CNT_W-1:0]  times;
  logic              start;
  logic              clr;
  logic              busy;
  logic [CH*DW-1:0]  max;
  logic [CH*DW-1:0]  min;
  logic [CH*DW-1:0]  vpp;
  logic              done;
  logic              valid;

  int checks = 0;
  int errors = 0;

  vpp_track_mc #(
    .DW       (DW),
    .CH       (CH),
    .CNT_W    (CNT_W),
    .AVG_LOG2 (AVG_LOG2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .din       (din),
    .times     (times),
    .start     (start),
    .clr       (clr),
    .busy      (busy),
    .max       (max),
    .min       (min),
    .vpp       (vpp),
    .done      (done),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CH*DW-1:0] pk(input int c1, input int c0);
    return {DW'(c1), DW'(c0)};
  endfunction

  // One strobed sample, channel 0 first
  task automatic samp(input int c0, input int c1);
    din       = pk(c1, c0);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic go(input int n);
    times = CNT_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int pulses;
    int consec;
    logic prev_done;

    rst_n = 1'b0; sample_en = 1'b0; din = '0; times = '0; start = 1'b0; clr = 1'b0;
    repeat (3) tick();
    chk("rst_busy",  busy,  0);
    chk("rst_done",  done,  0);
    chk("rst_valid", valid, 0);
    chk("rst_max",   max,   0);
    chk("rst_min",   min,   0);
    chk("rst_vpp",   vpp,   0);
    rst_n = 1'b1;
    repeat (3) tick();

`ifdef VPP_AVG_EN
    // Four windows of two samples: vpp 100,200,300,401 -> mean 250
    go(2);
    samp(0, 5); samp(100, 5);
    chk("avg_w1_nodone", done, 0);
    samp(0, 5); samp(200, 5);
    chk("avg_w2_nodone", done, 0);
    samp(0, 5); samp(300, 5);
    chk("avg_w3_nodone", done, 0);
    samp(0, 5); samp(401, 5);
    chk("avg_close_nodone", done, 0);
    tick();
    chk("avg_done",  done, 1);
    chk("avg_vpp",   vpp,  pk(0, 250));
    chk("avg_max",   max,  pk(5, 401));
    chk("avg_min",   min,  pk(5, 0));
    chk("avg_valid", valid, 1);
    tick();
    chk("avg_done_low", done, 0);
`else
    // Basic window of four samples
    go(4);
    chk("t1_busy", busy, 1);
    samp(100, 2048); samp(900, 2048); samp(50, 2048); samp(400, 2048);
    chk("t1_done_early", done, 0);
    tick();
    chk("t1_done",  done,  1);
    chk("t1_max",   max,   pk(2048, 900));
    chk("t1_min",   min,   pk(2048, 50));
    chk("t1_vpp",   vpp,   pk(0, 850));
    chk("t1_valid", valid, 1);
    chk("t1_busy_low", busy, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // times=0 acts as a single-sample window
    go(0);
    samp(77, 5);
    tick();
    chk("t2_done", done, 1);
    chk("t2_max",  max,  pk(5, 77));
    chk("t2_min",  min,  pk(5, 77));
    chk("t2_vpp",  vpp,  pk(0, 0));
    tick();

    // Abort after 2 of 8 samples
    go(8);
    samp(1, 2); samp(3, 4);
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    chk("t3_busy",   busy, 0);
    chk("t3_done",   done, 0);
    chk("t3_max",    max,  pk(5, 77));
    chk("t3_valid",  valid, 1);
    tick();
    chk("t3_done2",  done, 0);
    // Fresh run; a start during ACC must not restart it
    go(2);
    samp(10, 20);
    din = pk(5, 30); sample_en = 1'b1; start = 1'b1;
    tick();
    sample_en = 1'b0; start = 1'b0;
    tick();
    chk("t3b_done", done, 1);
    chk("t3b_max",  max,  pk(20, 30));
    chk("t3b_min",  min,  pk(5, 10));
    chk("t3b_vpp",  vpp,  pk(15, 20));
    tick();

    // Reset pulse mid-window
    go(4);
    samp(11, 12); samp(13, 14);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t4_busy",  busy,  0);
    chk("t4_valid", valid, 0);
    chk("t4_max",   max,   0);
    chk("t4_min",   min,   0);
    chk("t4_vpp",   vpp,   0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_nodone", done, 0);
      tick();
    end
    go(3);
    samp(7, 7); samp(9, 1); samp(8, 4);
    tick();
    chk("t4_done",  done,  1);
    chk("t4_vpp",   vpp,   pk(6, 2));
    chk("t4_max",   max,   pk(7, 9));
    chk("t4_valid", valid, 1);
    tick();

    // start held, one strobe every third cycle, times=3: done after edges
    // 10,19,28,37; windows are ch0 = 10*edge at edges 3k..3k+6
    pulses = 0; consec = 0; prev_done = 1'b0;
    times = CNT_W'(3);
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sample_en = (i % 3 == 0);
      din       = pk(0, i * 10);
      tick();
      if (done) begin
        chk("t5_vpp", vpp, pk(0, 60));
        chk("t5_max", max, pk(0, 90 * (pulses + 1)));
        pulses++;
        if (prev_done) consec++;
      end
      prev_done = done;
    end
    start = 1'b0; sample_en = 1'b0;
    chk("t5_pulses", pulses, 4);
    chk("t5_consec", consec, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_clr_busy", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
